dcache_responder: RTL and testbench
===================================

Name: dcache_responder

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits on the responder side of the processor's DCACHE port (stall/ren/wen/30-bit word addr/rdata/wdata).
- Serves hits with zero added latency. Holds `proc_stall` high while it writes back a dirty victim and refills a 4-word block from a slow 128-bit memory.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two, at least 2.
- IDX_W, $clog2(NUM_BLOCKS), index width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- proc_read  input  1  processor load request.
- proc_write  input  1  processor store request.
- proc_addr  input  30  word address: [1:0] word-in-block, [IDX_W+1:2] index, [29:IDX_W+2] tag.
- proc_wdata  input  32  store data.
- proc_rdata  output  32  load data.
- proc_stall  output  1  request not yet complete; processor holds all request inputs stable.
- mem_read  output  1  block refill request.
- mem_write  output  1  block write-back request.
- mem_addr  output  28  block address, equal to word address [29:2].
- mem_wdata  output  128  write-back block; word 0 in [31:0].
- mem_rdata  input  128  refill block; word 0 in [31:0].
- mem_ready  input  1  one-cycle pulse completing the current mem_read or mem_write.

Behaviour:
- Storage per line: valid, dirty, tag (28-IDX_W bits), 128-bit data. No reset on the data array.
- Reset (async, rst=1):
  - State goes to COMPARE; all valid and dirty bits clear.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0.
  - proc_stall = (proc_read|proc_write), combinational, so it is 1 if a request is present.
- Request validity: a request exists when proc_read|proc_write. If both are 1, treat as a write.
- hit = valid[idx] & (tag[idx]==proc_addr tag field).
- State COMPARE:
  - No request: proc_stall=0, no memory activity.
  - Read hit: proc_stall=0 in the same cycle. proc_rdata is combinational, the selected word of line idx.
  - Write hit: proc_stall=0. On the clock edge, write proc_wdata into the selected word and set dirty[idx]=1.
  - Miss: proc_stall=1. Go to WRITEBACK if valid[idx]&dirty[idx], else to ALLOCATE.
  - proc_rdata holds its previous value when not serving a read hit.
- State WRITEBACK:
  - proc_stall=1, mem_write=1, mem_addr={tag[idx],idx}, mem_wdata=data[idx].
  - Outputs are registered and stable for the whole state.
  - On mem_ready: dirty[idx]=0, go to ALLOCATE.
- State ALLOCATE:
  - proc_stall=1, mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready: data[idx]=mem_rdata, tag updated, valid=1, dirty=0, go to COMPARE.
  - The request then hits in COMPARE on the following cycle. Total miss latency = memory cycles + 1.
- mem_read and mem_write are never both 1.
- Both drop in the cycle after mem_ready is sampled; mem_ready seen outside WRITEBACK/ALLOCATE is ignored.
- Request inputs changing while stalled is a processor protocol violation; the cache uses proc_addr as currently presented.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE aborts immediately. The in-flight block is lost; there is no partial fill.
- Lines conflicting on the same index evict each other. Tag compare uses the full tag width; there is no partial match.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- When defined, two extra outputs are present:
  - perf_hit, 32 bits: increments once per completed request that hit on first lookup.
  - perf_miss, 32 bits: increments once per miss entry from COMPARE.
- Both counters reset to 0 and wrap modulo 2^32.
- The refill-completing re-lookup does not count as a hit.
- When undefined, neither port nor counter logic exists; behaviour is otherwise identical.

Test Plan:
- After reset, read addr 0x0000010 with mem_ready returning after 3 cycles and mem_rdata=0x44443333_22221111_00000000_AAAAAAAA:
  - proc_stall=1; mem_read=1 with mem_addr=0x0000004.
  - Then one cycle in COMPARE with proc_stall=0 and proc_rdata=0xAAAAAAAA.
- Back-to-back reads of addr 0x11 and 0x13 after that fill -> both proc_stall=0 in the same cycle; rdata 0x00000000 then 0x44443333.
- Write 0xDEADBEEF to 0x12 (hit), then read 0x12 -> no stall on either; read returns 0xDEADBEEF; mem_read=mem_write=0 throughout.
- Read 0x30 (same index 4, different tag) while line is dirty:
  - mem_write=1, mem_addr=0x0000004, mem_wdata word2=0xDEADBEEF.
  - After mem_ready, mem_read=1 with mem_addr=0x000000C.
  - Final data is word0 of the new block.
- Assert rst during ALLOCATE -> mem_read falls without a clock edge; the next read to the same address misses again (valid cleared).
- proc_read=proc_write=1 to a hit address -> treated as write; dirty set; a subsequent read returns proc_wdata.

Source files
------------

// File: rtl/dcache_responder_if.sv
// dcache_responder_if
//   Bundles the processor-side DCACHE port and the block-memory port of the
//   data cache into one interface.
//   Modports:
//     slave  - the cache: answers processor requests and masters the memory.
//     master - the environment: the processor issuing requests plus the
//              memory answering refills and write-backs.
//   Signals:
//     proc_read/proc_write/proc_addr[29:0]/proc_wdata[31:0]  processor request
//     proc_rdata[31:0]/proc_stall                            cache response
//     mem_read/mem_write/mem_addr[27:0]/mem_wdata[127:0]     block request
//     mem_rdata[127:0]/mem_ready                             memory response
interface dcache_responder_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata,
    output proc_rdata, proc_stall,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata,
    input  proc_rdata, proc_stall,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dcache_responder.sv
// dcache_responder
//   Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
//   Hits complete in the request cycle; misses stall the processor while a
//   dirty victim is written back and the new block is refilled.
//   Ports:
//     clk                 rising-edge clock
//     rst                 asynchronous active-high reset
//     bus (slave)         processor DCACHE port and 128-bit block-memory port
//     perf_hit[31:0]      first-lookup hit count   (DCACHE_PERF_CNT_EN only)
//     perf_miss[31:0]     miss count               (DCACHE_PERF_CNT_EN only)
//   Optional feature macro: DCACHE_PERF_CNT_EN adds the two performance
//   counters; without it the ports and counters do not exist.
module dcache_responder #(
  parameter int NUM_BLOCKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  dcache_responder_if.slave  bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]        perf_hit,
  output logic [31:0]        perf_miss
`endif
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    COMPARE   = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       word_sel;
  logic             req;
  logic             hit;
  logic [31:0]      sel_word;

  logic             stall;
  logic             read_hit;
  logic             write_hit;
  logic             start_wb;
  logic             start_alloc;
  logic             clear_dirty;
  logic             fill_en;

  logic             mem_read_q;
  logic             mem_write_q;
  logic [27:0]      mem_addr_q;
  logic [127:0]     mem_wdata_q;
  logic [31:0]      rdata_q;

  // Address decode and lookup; a simultaneous read and write counts as a write
  assign idx      = bus.proc_addr[IDX_W+1:2];
  assign req_tag  = bus.proc_addr[29:IDX_W+2];
  assign word_sel = bus.proc_addr[1:0];
  assign req      = bus.proc_read | bus.proc_write;
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign sel_word = data_q[idx][{word_sel, 5'b00000} +: 32];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COMPARE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state  = state;
    stall       = 1'b1;
    read_hit    = 1'b0;
    write_hit   = 1'b0;
    start_wb    = 1'b0;
    start_alloc = 1'b0;
    clear_dirty = 1'b0;
    fill_en     = 1'b0;
    case (state)
      COMPARE: begin
        stall = req & ~hit;
        if (req && hit) begin
          write_hit = bus.proc_write;
          read_hit  = ~bus.proc_write;
        end else if (req) begin
          if (valid_q[idx] && dirty_q[idx]) begin
            next_state = WRITEBACK;
            start_wb   = 1'b1;
          end else begin
            next_state  = ALLOCATE;
            start_alloc = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ready) begin
          next_state  = ALLOCATE;
          clear_dirty = 1'b1;
          start_alloc = 1'b1;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          next_state = COMPARE;
          fill_en    = 1'b1;
        end
      end
      default: begin
        next_state = COMPARE;
      end
    endcase
  end

  // Memory request registers: loaded on entry to WRITEBACK/ALLOCATE so they
  // stay stable for the whole state, and dropped after the fill completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (start_wb) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b1;
      mem_addr_q  <= {tag_q[idx], idx};
      mem_wdata_q <= data_q[idx];
    end else if (start_alloc) begin
      mem_read_q  <= 1'b1;
      mem_write_q <= 1'b0;
      mem_addr_q  <= bus.proc_addr[29:2];
    end else if (fill_en) begin
      mem_read_q  <= 1'b0;
    end
  end

  // Line status bits; these are the only cache state cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (fill_en) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (clear_dirty) begin
        dirty_q[idx] <= 1'b0;
      end
      if (write_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are left unreset; valid_q guards their contents
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[idx] <= bus.mem_rdata;
      tag_q[idx]  <= req_tag;
    end else if (write_hit) begin
      data_q[idx][{word_sel, 5'b00000} +: 32] <= bus.proc_wdata;
    end
  end

  // Load data is passed through on a read hit and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (read_hit) begin
      rdata_q <= sel_word;
    end
  end

  assign bus.proc_rdata = read_hit ? sel_word : rdata_q;
  assign bus.proc_stall = stall;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
  logic refill_pending;

  // refill_pending marks the re-lookup that follows a refill so that it is
  // not mistaken for a first-lookup hit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit       <= '0;
      perf_miss      <= '0;
      refill_pending <= 1'b0;
    end else if (state == COMPARE && req) begin
      if (hit) begin
        if (!refill_pending) begin
          perf_hit <= perf_hit + 32'd1;
        end
        refill_pending <= 1'b0;
      end else begin
        perf_miss      <= perf_miss + 32'd1;
        refill_pending <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// tb_dcache_responder
//   Directed testbench for dcache_responder: drives processor requests and
//   hand-timed memory responses through the interface and compares outputs
//   against hand-computed values.
//   Build with DCACHE_PERF_CNT_EN defined to also cover the counters.
module tb_dcache_responder;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  dcache_responder_if bus ();

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  dcache_responder #(.NUM_BLOCKS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .perf_hit  (perf_hit),
    .perf_miss (perf_miss)
`endif
  );

  localparam logic [127:0] BLK_A = 128'h44443333_22221111_00000000_AAAAAAAA;
  localparam logic [127:0] BLK_B = 128'h33333333_22222222_11111111_5A5A5A5A;
  localparam logic [127:0] BLK_C = 128'h77777777_66666666_11111111_99999999;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log mismatches
  task automatic checkOutput(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a new processor request just after the falling edge
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [29:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.proc_read  = rd;
    bus.proc_write = wr;
    bus.proc_addr  = addr;
    bus.proc_wdata = wd;
    #2;
  endtask

  // Pulse mem_ready for one cycle, 'delay' cycles after the current one
  task automatic memPulse(input int delay, input logic [127:0] data);
    repeat (delay - 1) @(negedge clk);
    bus.mem_rdata = data;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst            = 1'b1;
    bus.proc_read  = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr  = '0;
    bus.proc_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
    #12;
    $display("[TB] reset state");
    checkOutput("rst_mem_read",  bus.mem_read,   0);
    checkOutput("rst_mem_write", bus.mem_write,  0);
    checkOutput("rst_mem_addr",  bus.mem_addr,   0);
    checkOutput("rst_mem_wdata", bus.mem_wdata,  0);
    checkOutput("rst_rdata",     bus.proc_rdata, 0);
    checkOutput("rst_stall_idle", bus.proc_stall, 0);
    bus.proc_read = 1'b1;
    #1;
    checkOutput("rst_stall_req", bus.proc_stall, 1);
    bus.proc_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] cold read miss to 0x10");
    applyStimulus(1, 0, 30'h10, 0);
    checkOutput("miss_stall",      bus.proc_stall, 1);
    checkOutput("miss_no_mem_yet", bus.mem_read,   0);
    @(negedge clk); #2;
    checkOutput("alloc_mem_read",  bus.mem_read,   1);
    checkOutput("alloc_mem_write", bus.mem_write,  0);
    checkOutput("alloc_mem_addr",  bus.mem_addr,   28'h4);
    checkOutput("alloc_stall",     bus.proc_stall, 1);
    memPulse(3, BLK_A);
    checkOutput("fill_stall",      bus.proc_stall, 0);
    checkOutput("fill_rdata",      bus.proc_rdata, 32'hAAAAAAAA);
    checkOutput("fill_mem_read",   bus.mem_read,   0);

    $display("[TB] back-to-back read hits");
    applyStimulus(1, 0, 30'h11, 0);
    checkOutput("hit11_stall", bus.proc_stall, 0);
    checkOutput("hit11_rdata", bus.proc_rdata, 32'h00000000);
    applyStimulus(1, 0, 30'h13, 0);
    checkOutput("hit13_stall", bus.proc_stall, 0);
    checkOutput("hit13_rdata", bus.proc_rdata, 32'h44443333);
    applyStimulus(0, 0, 30'h13, 0);
    checkOutput("rdata_hold",  bus.proc_rdata, 32'h44443333);

    $display("[TB] write hit then read back");
    applyStimulus(0, 1, 30'h12, 32'hDEADBEEF);
    checkOutput("wr12_stall",     bus.proc_stall, 0);
    checkOutput("wr12_mem_read",  bus.mem_read,   0);
    checkOutput("wr12_mem_write", bus.mem_write,  0);
    applyStimulus(1, 0, 30'h12, 0);
    checkOutput("rd12_stall",     bus.proc_stall, 0);
    checkOutput("rd12_rdata",     bus.proc_rdata, 32'hDEADBEEF);
    checkOutput("rd12_mem_write", bus.mem_write,  0);

    $display("[TB] conflict miss with dirty victim");
    applyStimulus(1, 0, 30'h30, 0);
    checkOutput("rd30_stall",   bus.proc_stall, 1);
    @(negedge clk); #2;
    checkOutput("wb_mem_write", bus.mem_write,  1);
    checkOutput("wb_mem_read",  bus.mem_read,   0);
    checkOutput("wb_mem_addr",  bus.mem_addr,   28'h4);
    checkOutput("wb_word2",     bus.mem_wdata[95:64], 32'hDEADBEEF);
    checkOutput("wb_block",     bus.mem_wdata,
                128'h44443333_DEADBEEF_00000000_AAAAAAAA);
    memPulse(2, 128'h0);
    checkOutput("wb2al_mem_write", bus.mem_write, 0);
    checkOutput("wb2al_mem_read",  bus.mem_read,  1);
    checkOutput("wb2al_mem_addr",  bus.mem_addr,  28'hC);
    checkOutput("wb2al_stall",     bus.proc_stall, 1);
    memPulse(1, BLK_B);
    checkOutput("rd30_stall_done", bus.proc_stall, 0);
    checkOutput("rd30_rdata",      bus.proc_rdata, 32'h5A5A5A5A);

    $display("[TB] reset during allocate");
    applyStimulus(1, 0, 30'h10, 0);
    checkOutput("rd10_stall", bus.proc_stall, 1);
    @(negedge clk); #2;
    checkOutput("rd10_clean_alloc", bus.mem_read,  1);
    checkOutput("rd10_no_wb",       bus.mem_write, 0);
    rst = 1'b1;
    #1;
    checkOutput("abort_mem_read", bus.mem_read,   0);
    checkOutput("abort_mem_addr", bus.mem_addr,   0);
    checkOutput("abort_stall",    bus.proc_stall, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("remiss_stall",    bus.proc_stall, 1);
    checkOutput("remiss_mem_read", bus.mem_read,   0);
    @(negedge clk); #2;
    checkOutput("remiss_alloc",    bus.mem_read,   1);
    checkOutput("remiss_no_wb",    bus.mem_write,  0);
    checkOutput("remiss_addr",     bus.mem_addr,   28'h4);
    memPulse(1, BLK_A);
    checkOutput("refill_stall", bus.proc_stall, 0);
    checkOutput("refill_rdata", bus.proc_rdata, 32'hAAAAAAAA);

    $display("[TB] stray mem_ready while idle");
    applyStimulus(0, 0, 30'h10, 0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #2;
    checkOutput("stray_mem_read",  bus.mem_read,   0);
    checkOutput("stray_mem_write", bus.mem_write,  0);
    checkOutput("stray_stall",     bus.proc_stall, 0);

    $display("[TB] simultaneous read and write");
    applyStimulus(1, 1, 30'h11, 32'hCAFEF00D);
    checkOutput("rw_stall",      bus.proc_stall, 0);
    checkOutput("rw_rdata_hold", bus.proc_rdata, 32'hAAAAAAAA);
    applyStimulus(1, 0, 30'h11, 0);
    checkOutput("rw_readback",   bus.proc_rdata, 32'hCAFEF00D);
    applyStimulus(1, 0, 30'h31, 0);
    checkOutput("rd31_stall",    bus.proc_stall, 1);
    @(negedge clk); #2;
    checkOutput("rw_dirty_wb",   bus.mem_write,  1);
    checkOutput("rw_wb_addr",    bus.mem_addr,   28'h4);
    checkOutput("rw_wb_block",   bus.mem_wdata,
                128'h44443333_22221111_CAFEF00D_AAAAAAAA);
    memPulse(1, 128'h0);
    checkOutput("rd31_alloc",    bus.mem_read,   1);
    checkOutput("rd31_addr",     bus.mem_addr,   28'hC);
    memPulse(1, BLK_C);
    checkOutput("rd31_rdata",    bus.proc_rdata, 32'h11111111);
    checkOutput("rd31_done",     bus.proc_stall, 0);

`ifdef DCACHE_PERF_CNT_EN
    applyStimulus(0, 0, 30'h0, 0);
    checkOutput("perf_hit",  perf_hit,  32'd2);
    checkOutput("perf_miss", perf_miss, 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
